// File: rtl/rv64im_vhm_ifu.sv
// Instruction fetch unit for the RV64IM virtual hardware machine.
// Owns the fetch PC, keeps one word read outstanding to instruction memory,
// buffers returned words with their PCs, and hands them to the execute core.
// A redirect from the core flushes the buffer and discards any in-flight word.
module rv64im_vhm_ifu #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] riscv_32bits_instruction,
    output logic [63:0] inst_pc
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [63:0]     req_pc_q, req_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [63:0]     fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];

    logic            req_fire;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsbs;

    // The low two bits of the redirect target are forced to zero.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request is offered only in REQ with buffer space, and never while reset is held.
    assign imem_req_valid = !rst && (state_q == S_REQ) && (count_q < CW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A returning word is buffered only when it is not killed by a same-cycle redirect.
    assign push = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign pop  = inst_valid && inst_ready;

    // Head of buffer; zero when empty so the core never sees stale contents.
    assign inst_valid               = (count_q != '0);
    assign riscv_32bits_instruction = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    assign inst_pc                  = inst_valid ? fifo_pc_q[rd_ptr_q]   : 64'h0;

    // Fetch FSM next-state: REQ issues, WAIT collects, DROP swallows a cancelled word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // PC and buffer bookkeeping; redirect overrides increment, push and pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
        end
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            fifo_inst_q[wr_ptr_q] <= imem_resp_data;
        end
    end

endmodule

// File: doc/rv64im_vhm_ifu.md
# rv64im_vhm_ifu

Instruction fetch unit for the RV64IM virtual hardware machine. It sits directly upstream of the VHM execute core. It owns the fetch program counter and issues word reads to instruction memory over a valid/ready request channel. Returned words are buffered with their PCs in a small FIFO and presented to the core on `riscv_32bits_instruction` with a valid/ready handshake. When the core resolves a taken branch or jump, it redirects fetch, which flushes the FIFO and discards any in-flight response.

## Interface
- `RESET_PC`, 64'h0000_0000_8000_0000: fetch PC loaded on reset.
- `FIFO_DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `clk` in 1: VHM clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 64: word-aligned fetch address; equals fetch_pc.
- `imem_resp_valid` in 1: response word valid. Responses are in order, ≥1 cycle after acceptance, and cannot be back-pressured.
- `imem_resp_data` in 32: fetched instruction word.
- `redirect_valid` in 1: core requests a fetch redirect (one-cycle pulse).
- `redirect_pc` in 64: new fetch PC; bits [1:0] are ignored and forced to 0.
- `inst_valid` out 1: FIFO head is valid.
- `inst_ready` in 1: core consumes the head this cycle.
- `riscv_32bits_instruction` out 32: FIFO head instruction.
- `inst_pc` out 64: PC of the FIFO head instruction.

## Operation
- State registers:
  - fetch_pc (64b).
  - req_pc (PC of the outstanding request).
  - FIFO of {pc, inst} with count 0..FIFO_DEPTH.
  - FSM with states REQ, WAIT, DROP.
- At most one request is outstanding at any time.
- REQ state:
  - `imem_req_valid` = (count < FIFO_DEPTH).
  - On handshake: req_pc ← fetch_pc; fetch_pc ← fetch_pc+4, 64-bit wrap.
  - Next state is WAIT, or DROP if `redirect_valid` is high in the same cycle.
- WAIT state:
  - On `imem_resp_valid`: push {req_pc, imem_resp_data} and go to REQ.
  - If `redirect_valid` is high in the same cycle, discard the response instead of pushing it, and go to REQ.
  - `redirect_valid` without a response: go to DROP.
- DROP state:
  - On `imem_resp_valid`: discard the word and go to REQ.
  - No request is issued while in DROP.
- Redirect, in any state:
  - FIFO is flushed (count ← 0).
  - fetch_pc ← {redirect_pc[63:2], 2'b00}.
  - Redirect has priority over a pop, a push, and the fetch_pc increment in the same cycle.
- Output side:
  - `inst_valid` = (count ≠ 0).
  - The head is popped on `inst_valid & inst_ready`.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Overflow is impossible by construction: a request is issued only when count < FIFO_DEPTH, and count cannot grow while the request is outstanding.
- Unaligned fetch and access faults are not detected by this block.

## Timing
- Reset values (async assert):
  - fetch_pc = RESET_PC; FSM = REQ; count = 0.
  - `inst_valid` = 0; `imem_req_valid` = 0 while `rst` is high.
  - `riscv_32bits_instruction` and `inst_pc` read as 0 when empty.
- First request: `imem_req_valid` = 1 with address RESET_PC in the first cycle after `rst` deasserts.
- Reset asserted mid-operation:
  - All state is cleared immediately and any outstanding response is forgotten.
  - Memory must not return a response after reset.
- Request-channel stability: `imem_req_addr` is stable while `imem_req_valid` is high and `imem_req_ready` is low, except on a redirect, where the address changes to the redirect target the next cycle.
- Fetch-to-issue latency: a response at edge N makes `inst_valid` high after edge N (registered FIFO). The next request is issued from cycle N+1.
- Throughput: with 1-cycle memory, one instruction per 2 cycles.
- Redirect at edge N:
  - If nothing is outstanding: `inst_valid` = 0 and `imem_req_addr` = redirect_pc from cycle N+1.
  - If a request is outstanding: the next request is issued the cycle after the dropped response arrives.

## Test plan
- Reset release, memory always ready with 1-cycle latency, `inst_ready`=1:
  - Core sees PCs 0x80000000, 0x80000004, 0x80000008 in order with matching data.
  - `inst_valid` is first high 2 cycles after reset release.
- Back-pressure, `inst_ready`=0 for 10 cycles:
  - count saturates at 2 and `imem_req_valid` drops to 0.
  - When ready returns, the heads pop in order and fetching resumes at 0x80000008.
- Redirect to 0x80001002 while a request is in WAIT with memory latency 3:
  - The stale response is dropped and the FIFO is empty.
  - The next request address is 0x80001000, and the first delivered `inst_pc` is 0x80001000.
- Redirect and `imem_resp_valid` in the same cycle, FIFO holding one entry:
  - Both the entry and the response are discarded.
  - The next `imem_req_addr` is the redirect PC one cycle later.
- PC wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC.
  - The following request address is 0x0000_0000_0000_0000.
- Async `rst` pulse mid-WAIT:
  - Outputs clear with no clock edge.
  - After release, fetch restarts at RESET_PC with no stale instruction delivered.
